// File: rtl/fir_mac_if.sv
// Handshake and read-port bundle between the FIR MAC engine and its
// coefficient/delay-chain source and output register stage.
interface fir_mac_if #(
  parameter int DATA_W  = 16,
  parameter int COEFF_W = 16,
  parameter int OUT_W   = 16,
  parameter int ADDR_W  = 4
);
  logic                      start;
  logic signed [DATA_W-1:0]  tap;
  logic signed [COEFF_W-1:0] coeff;
  logic [ADDR_W-1:0]         addr;
  logic                      busy;
  logic signed [OUT_W-1:0]   mac;
  logic                      valid;
  logic                      sat;

  modport master (
    output start, tap, coeff,
    input  addr, busy, mac, valid, sat
  );

  modport slave (
    input  start, tap, coeff,
    output addr, busy, mac, valid, sat
  );
endinterface

// File: rtl/fir_mac_seq.sv
// Sequential FIR multiply-accumulate: walks TAPS pairs, scales, saturates.
// Define FIR_MAC_ROUND_EN for round-half-up before the scaling shift.
module fir_mac_seq #(
  parameter int TAPS    = 10,
  parameter int DATA_W  = 16,
  parameter int COEFF_W = 16,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 15
) (
  input  logic      clk,
  input  logic      rst,
  fir_mac_if.slave  bus
);
  localparam int AW    = $clog2(TAPS);
  localparam int PW    = DATA_W + COEFF_W;
  localparam int ACC_W = PW + AW;
  localparam int SW    = ACC_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic signed [SW-1:0] MAXV =
    {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV =
    {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0]               state;
  logic [AW-1:0]            addr_q;
  logic                     rd_v;
  logic                     mul_v;
  logic                     drn;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [OUT_W-1:0]  mac_q;
  logic                     sat_q;

  logic signed [SW-1:0]     sum;
  logic signed [SW-1:0]     scaled;
  logic                     sat_hi;
  logic                     sat_lo;
  logic signed [OUT_W-1:0]  mac_d;

  // Final tap is folded in here so the result lands one cycle earlier
  always_comb begin
    sum = {acc[ACC_W-1], acc};
    if (mul_v)
      sum = sum + {{(SW-PW){prod[PW-1]}}, prod};
`ifdef FIR_MAC_ROUND_EN
    sum = sum + (SW'(1) <<< (SHIFT-1));
`endif
    scaled = sum >>> SHIFT;
    sat_hi = scaled > MAXV;
    sat_lo = scaled < MINV;
    mac_d  = scaled[OUT_W-1:0];
    if (sat_hi)
      mac_d = {1'b0, {(OUT_W-1){1'b1}}};
    else if (sat_lo)
      mac_d = {1'b1, {(OUT_W-1){1'b0}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      rd_v   <= 1'b0;
      mul_v  <= 1'b0;
      drn    <= 1'b0;
      prod   <= '0;
      acc    <= '0;
      mac_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      rd_v  <= (state == FETCH);
      mul_v <= rd_v;
      if (rd_v)
        prod <= bus.tap * bus.coeff;
      if (mul_v)
        acc <= acc + ACC_W'(prod);
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.start) begin
            state  <= FETCH;
            addr_q <= '0;
            acc    <= '0;
            rd_v   <= 1'b0;
            mul_v  <= 1'b0;
          end
        end
        (state == FETCH): begin
          if (addr_q == AW'(TAPS-1)) begin
            state <= DRAIN;
            drn   <= 1'b0;
          end else begin
            addr_q <= addr_q + AW'(1);
          end
        end
        (state == DRAIN): begin
          if (drn) begin
            state <= DONE;
            mac_q <= mac_d;
            sat_q <= sat_hi | sat_lo;
          end else begin
            drn <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.addr  = addr_q;
  assign bus.busy  = (state != IDLE);
  assign bus.valid = (state == DONE);
  assign bus.mac   = mac_q;
  assign bus.sat   = sat_q;
endmodule
